// File: rtl/easyobv_axil_pkg.sv
// Shared constants, register decode types and the write-channel state
// encoding for the easyobv AXI4-Lite register file.
package easyobv_axil_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_ID     = 8'h08;
    localparam logic [7:0] CNT_BASE    = 8'h10;
    localparam int         CNT_STRIDE  = 8;
    localparam int         NUM_CNT     = 9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_PAUSE_BIT       = 0;
    localparam int CTRL_TIMEOUT_CLR_BIT = 1;
    localparam int CTRL_W               = 2;

    // Number of 32-bit words occupied by the LO/HI counter pairs.
    localparam logic [5:0] CNT_WORDS = 6'(NUM_CNT * CNT_STRIDE / 4);

    typedef enum logic [2:0] {
        WR_INIT,
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_COMMIT,
        WR_RESP
    } wr_state_e;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_ID,
        REG_CNT,
        REG_BAD
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [3:0] idx;
        logic       hi;
    } reg_sel_t;

    // Decode a word address (byte address bits [7:2]) into a register selector.
    function automatic reg_sel_t decode_word(input logic [5:0] word);
        reg_sel_t   sel;
        logic [5:0] off;
        sel.kind = REG_BAD;
        sel.idx  = 4'd0;
        sel.hi   = 1'b0;
        off      = word - CNT_BASE[7:2];
        if (word == ADDR_CTRL[7:2]) begin
            sel.kind = REG_CTRL;
        end else if (word == ADDR_STATUS[7:2]) begin
            sel.kind = REG_STATUS;
        end else if (word == ADDR_ID[7:2]) begin
            sel.kind = REG_ID;
        end else if (off < CNT_WORDS) begin
            sel.kind = REG_CNT;
            sel.idx  = off[4:1];
            sel.hi   = off[0];
        end
        return sel;
    endfunction

endpackage

// File: rtl/easyobv_axil_if.sv
// AXI4-Lite bus bundle between software master and the register file.
interface easyobv_axil_if #(
    parameter int ADDR_W = 8
);
    // Every channel transfers on a rising edge where valid and ready are both
    // high; a source holds valid and its payload stable until that edge.
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/easyobv_axil_wr_ctrl.sv
// Write-channel controller: captures AW and W independently, issues a one-cycle
// commit strobe once both are held, then presents B until accepted.
module easyobv_axil_wr_ctrl
    import easyobv_axil_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    input  logic [1:0]        wr_resp,
    output wr_state_e         state_dbg
);

    wr_state_e state_q, state_d;
    logic      aw_hs, w_hs;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WR_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            if (aw_hs) wr_addr <= awaddr;
            if (w_hs) begin
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            if (commit) bresp <= wr_resp;
        end
    end

    // WR_INIT keeps both readies low for the first cycle out of reset.
    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            WR_INIT: state_d = WR_IDLE;
            WR_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) state_d = WR_COMMIT;
                else if (awvalid)      state_d = WR_HAVE_AW;
                else if (wvalid)       state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: begin
                wready = 1'b1;
                if (wvalid) state_d = WR_COMMIT;
            end
            WR_HAVE_W: begin
                awready = 1'b1;
                if (awvalid) state_d = WR_COMMIT;
            end
            WR_COMMIT: begin
                commit  = 1'b1;
                state_d = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) state_d = WR_IDLE;
            end
            default: state_d = WR_INIT;
        endcase
    end

endmodule

// File: rtl/easyobv_axil_regs.sv
// AXI4-Lite register file exposing CTRL/STATUS/ID and nine 64-bit counters,
// with a coherent LO-then-HI read through a single hi-word shadow.
module easyobv_axil_regs
    import easyobv_axil_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] ID_VALUE = 32'h0BB5_0001
) (
    input  logic                s_axil_aclk,
    input  logic                rst,
    easyobv_axil_if.slave       s_axil,
    output logic                pause_axil,
    output logic                timeout_clr_axil,
    input  logic                timeout_axil,
    input  logic [63:0]         mismatch_cnt_axil,
    input  logic [63:0]         tx_pkt_cnt_axil,
    input  logic [63:0]         tx_pkt_time_cnt_axil,
    input  logic [63:0]         tx_pkt_timestamp_sum_axil,
    input  logic [63:0]         tx_transferred_size_axil,
    input  logic [63:0]         rx_pkt_cnt_axil,
    input  logic [63:0]         rx_pkt_time_cnt_axil,
    input  logic [63:0]         rx_pkt_timestamp_sum_axil,
    input  logic [63:0]         rx_transferred_size_axil
);

    logic [63:0] cnt [NUM_CNT];

    assign cnt[0] = mismatch_cnt_axil;
    assign cnt[1] = tx_pkt_cnt_axil;
    assign cnt[2] = tx_pkt_time_cnt_axil;
    assign cnt[3] = tx_pkt_timestamp_sum_axil;
    assign cnt[4] = tx_transferred_size_axil;
    assign cnt[5] = rx_pkt_cnt_axil;
    assign cnt[6] = rx_pkt_time_cnt_axil;
    assign cnt[7] = rx_pkt_timestamp_sum_axil;
    assign cnt[8] = rx_transferred_size_axil;

    // ---------------- write path ----------------
    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [1:0]        wr_resp;
    wr_state_e         wr_state_dbg;
    reg_sel_t          wr_sel;
    logic [CTRL_W-1:0] ctrl_q;

    easyobv_axil_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr_ctrl (
        .clk       (s_axil_aclk),
        .rst       (rst),
        .awaddr    (s_axil.awaddr),
        .awvalid   (s_axil.awvalid),
        .awready   (s_axil.awready),
        .wdata     (s_axil.wdata),
        .wstrb     (s_axil.wstrb),
        .wvalid    (s_axil.wvalid),
        .wready    (s_axil.wready),
        .bresp     (s_axil.bresp),
        .bvalid    (s_axil.bvalid),
        .bready    (s_axil.bready),
        .commit    (commit),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .wr_resp   (wr_resp),
        .state_dbg (wr_state_dbg)
    );

    assign wr_sel  = decode_word(wr_addr[7:2]);
    assign wr_resp = (wr_sel.kind == REG_BAD) ? RESP_SLVERR : RESP_OKAY;

    // Only CTRL is writable; read-only targets accept the write silently.
    always_ff @(posedge s_axil_aclk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (commit && wr_sel.kind == REG_CTRL && wr_strb[0]) begin
            ctrl_q <= wr_data[CTRL_W-1:0];
        end
    end

    assign pause_axil       = ctrl_q[CTRL_PAUSE_BIT];
    assign timeout_clr_axil = ctrl_q[CTRL_TIMEOUT_CLR_BIT];

    // ---------------- read path ----------------
    logic        live_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_hs, r_hs;
    reg_sel_t    rd_sel;
    logic [63:0] sel_cnt;
    logic [31:0] rd_data_c;
    logic [1:0]  rd_resp_c;
    logic [31:0] hi_shadow_q;
    logic        shadow_vld_q;
    logic [3:0]  shadow_idx_q;
    logic        shadow_hit;

    // live_q holds arready low while reset is asserted and for one cycle after.
    always_ff @(posedge s_axil_aclk or posedge rst) begin
        if (rst) live_q <= 1'b0;
        else     live_q <= 1'b1;
    end

    assign s_axil.arready = live_q && !rvalid_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    assign ar_hs  = s_axil.arvalid && s_axil.arready;
    assign r_hs   = rvalid_q && s_axil.rready;
    assign rd_sel = decode_word(s_axil.araddr[7:2]);

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel.idx == 4'(i)) sel_cnt = cnt[i];
        end
    end

    assign shadow_hit = shadow_vld_q && (shadow_idx_q == rd_sel.idx);

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        case (rd_sel.kind)
            REG_CTRL:   rd_data_c = {{(32-CTRL_W){1'b0}}, ctrl_q};
            REG_STATUS: rd_data_c = {31'd0, timeout_axil};
            REG_ID:     rd_data_c = ID_VALUE;
            REG_CNT: begin
                if (!rd_sel.hi)     rd_data_c = sel_cnt[31:0];
                else if (shadow_hit) rd_data_c = hi_shadow_q;
                else                 rd_data_c = sel_cnt[63:32];
            end
            default:    rd_resp_c = RESP_SLVERR;
        endcase
    end

    // A LO read snapshots the matching HI word so a following HI read of the
    // same counter sees a value coherent with the LO it was paired with.
    always_ff @(posedge s_axil_aclk or posedge rst) begin
        if (rst) begin
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            hi_shadow_q  <= '0;
            shadow_vld_q <= 1'b0;
            shadow_idx_q <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_c;
            rresp_q  <= rd_resp_c;
            if (rd_sel.kind == REG_CNT) begin
                if (!rd_sel.hi) begin
                    hi_shadow_q  <= sel_cnt[63:32];
                    shadow_vld_q <= 1'b1;
                    shadow_idx_q <= rd_sel.idx;
                end else if (shadow_hit) begin
                    shadow_vld_q <= 1'b0;
                end
            end
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, wr_addr, wr_data, wr_strb, wr_sel, wr_state_dbg, s_axil.araddr};

endmodule

// File: tb/tb_easyobv_axil_regs.sv
// Randomized scoreboard bench for easyobv_axil_regs: expected B/R responses are
// queued by the drivers from a software-level register model and popped by a monitor.
module tb_easyobv_axil_regs;

    localparam int          ADDR_W   = 8;
    localparam logic [31:0] ID_VALUE = 32'h0BB5_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    easyobv_axil_if #(.ADDR_W(ADDR_W)) bus ();

    logic        pause_axil, timeout_clr_axil, timeout_axil;
    logic [63:0] cnt_drv [9];

    easyobv_axil_regs #(.ADDR_W(ADDR_W), .ID_VALUE(ID_VALUE)) dut (
        .s_axil_aclk               (clk),
        .rst                       (rst),
        .s_axil                    (bus),
        .pause_axil                (pause_axil),
        .timeout_clr_axil          (timeout_clr_axil),
        .timeout_axil              (timeout_axil),
        .mismatch_cnt_axil         (cnt_drv[0]),
        .tx_pkt_cnt_axil           (cnt_drv[1]),
        .tx_pkt_time_cnt_axil      (cnt_drv[2]),
        .tx_pkt_timestamp_sum_axil (cnt_drv[3]),
        .tx_transferred_size_axil  (cnt_drv[4]),
        .rx_pkt_cnt_axil           (cnt_drv[5]),
        .rx_pkt_time_cnt_axil      (cnt_drv[6]),
        .rx_pkt_timestamp_sum_axil (cnt_drv[7]),
        .rx_transferred_size_axil  (cnt_drv[8])
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [33:0] exp_r_q[$];
    logic [1:0]  exp_b_q[$];

    // Software view of the register file.
    logic [1:0]  ctrl_m;
    bit          sh_vld_m;
    int          sh_k_m;
    logic [31:0] sh_val_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
    endtask

    function automatic bit is_cnt_addr(input logic [7:0] a);
        return (a >= 8'h10) && (a <= 8'h54);
    endfunction

    // Returns {rresp, rdata} for a read issued now and applies the shadow rules.
    function automatic logic [33:0] model_read(input logic [7:0] addr);
        logic [7:0] a;
        int         off, k;
        bit         hi;
        a = addr & 8'hFC;
        if (a == 8'h00) return {2'b00, 30'd0, ctrl_m};
        if (a == 8'h04) return {2'b00, 31'd0, timeout_axil};
        if (a == 8'h08) return {2'b00, ID_VALUE};
        if (is_cnt_addr(a)) begin
            off = int'(a) - 16;
            k   = off / 8;
            hi  = (off % 8) == 4;
            if (!hi) begin
                sh_vld_m = 1'b1;
                sh_k_m   = k;
                sh_val_m = cnt_drv[k][63:32];
                return {2'b00, cnt_drv[k][31:0]};
            end
            if (sh_vld_m && sh_k_m == k) begin
                sh_vld_m = 1'b0;
                return {2'b00, sh_val_m};
            end
            return {2'b00, cnt_drv[k][63:32]};
        end
        return {2'b10, 32'd0};
    endfunction

    function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [7:0] a;
        a = addr & 8'hFC;
        if (a == 8'h00) begin
            if (strb[0]) ctrl_m = data[1:0];
            return 2'b00;
        end
        if (a == 8'h04 || a == 8'h08 || is_cnt_addr(a)) return 2'b00;
        return 2'b10;
    endfunction

    // ---------------- monitor ----------------
    logic [33:0] mon_r;
    logic [1:0]  mon_b;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rvalid && bus.rready) begin
                if (exp_r_q.size() == 0) begin
                    timeout_fail("r_unexpected");
                end else begin
                    mon_r = exp_r_q.pop_front();
                    check("r_data", bus.rdata, mon_r[31:0]);
                    check("r_resp", bus.rresp, mon_r[33:32]);
                end
            end
            if (bus.bvalid && bus.bready) begin
                if (exp_b_q.size() == 0) begin
                    timeout_fail("b_unexpected");
                end else begin
                    mon_b = exp_b_q.pop_front();
                    check("b_resp", bus.bresp, mon_b);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] addr, input int r_delay);
        logic [33:0] e;
        bit          got;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = (r_delay == 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.arready) got = 1'b1;
        end
        if (!got) begin
            timeout_fail("ar_accept");
            bus.arvalid = 1'b0;
            return;
        end
        e = model_read(addr);
        exp_r_q.push_back(e);
        step();
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", bus.rvalid, 1);
        for (int i = 0; i < r_delay; i++) begin
            check("r_hold_data", bus.rdata, e[31:0]);
            check("r_hold_valid", bus.rvalid, 1);
            check("r_ar_blocked", bus.arready, 0);
            step();
            if (i == r_delay - 1) bus.rready = 1'b1;
            @(negedge clk);
        end
        step();
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_d, input int w_d, input int b_d);
        logic [1:0] old_ctrl;
        logic [1:0] e;
        bit         got_b;
        old_ctrl = ctrl_m;
        e = model_write(addr, data, strb);
        exp_b_q.push_back(e);
        bus.bready = 1'b0;
        fork
            begin
                bit got_aw;
                for (int i = 0; i < aw_d; i++) begin
                    @(negedge clk);
                    check("b_before_aw", bus.bvalid, 0);
                    step();
                end
                bus.awaddr  = addr;
                bus.awvalid = 1'b1;
                got_aw = 1'b0;
                for (int i = 0; i < 20 && !got_aw; i++) begin
                    @(negedge clk);
                    if (bus.awready) got_aw = 1'b1;
                end
                if (!got_aw) timeout_fail("aw_accept");
                step();
                bus.awvalid = 1'b0;
            end
            begin
                bit got_w;
                for (int i = 0; i < w_d; i++) begin
                    @(negedge clk);
                    check("b_before_w", bus.bvalid, 0);
                    step();
                end
                bus.wdata  = data;
                bus.wstrb  = strb;
                bus.wvalid = 1'b1;
                got_w = 1'b0;
                for (int i = 0; i < 20 && !got_w; i++) begin
                    @(negedge clk);
                    if (bus.wready) got_w = 1'b1;
                end
                if (!got_w) timeout_fail("w_accept");
                step();
                bus.wvalid = 1'b0;
            end
        join
        @(negedge clk);
        check("b_commit_cycle", bus.bvalid, 0);
        check("pause_before_commit", pause_axil, old_ctrl[0]);
        @(negedge clk);
        got_b = bus.bvalid;
        check("b_latency", bus.bvalid, 1);
        check("pause_at_commit", pause_axil, ctrl_m[0]);
        check("toclr_at_commit", timeout_clr_axil, ctrl_m[1]);
        for (int i = 0; i < b_d; i++) begin
            check("b_hold_valid", bus.bvalid, 1);
            check("b_hold_awready", bus.awready, 0);
            check("b_hold_wready", bus.wready, 0);
            step();
            @(negedge clk);
        end
        step();
        bus.bready = 1'b1;
        for (int i = 0; i < 10 && !got_b; i++) begin
            @(negedge clk);
            if (bus.bvalid) got_b = 1'b1;
        end
        step();
        bus.bready = 1'b0;
        if (!got_b) timeout_fail("b_response");
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        bus.bready  = 1'b0;
        bus.rready  = 1'b0;
        exp_r_q.delete();
        exp_b_q.delete();
        ctrl_m   = 2'b00;
        sh_vld_m = 1'b0;
        sh_k_m   = 0;
        sh_val_m = '0;
    endtask

    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
        return 8'($urandom_range(0, 23) * 4);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bus.awaddr   = '0;
        bus.wdata    = '0;
        bus.wstrb    = '0;
        bus.araddr   = '0;
        timeout_axil = 1'b0;
        for (int i = 0; i < 9; i++) cnt_drv[i] = {$urandom, $urandom};
        apply_reset();
        repeat (3) step();
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_pause", pause_axil, 0);
        check("rst_toclr", timeout_clr_axil, 0);
        rst = 1'b0;
        repeat (2) step();

        // AW and W together, then readback
        do_write(8'h00, 32'h3, 4'h1, 0, 0, 0);
        check("t1_pause", pause_axil, 1);
        check("t1_toclr", timeout_clr_axil, 1);
        do_read(8'h00, 0);

        // W ahead of AW, slow bready
        do_write(8'h00, 32'h0, 4'hF, 3, 0, 4);
        check("t2_pause", pause_axil, 0);

        // coherent 64-bit read
        cnt_drv[1] = 64'h1_FFFF_FFFF;
        do_read(8'h18, 0);
        cnt_drv[1] = 64'h2_0000_0000;
        do_read(8'h1C, 0);
        do_read(8'h1C, 0);

        // status, id, stalled rready
        timeout_axil = 1'b1;
        do_read(8'h04, 0);
        do_read(8'h08, 2);

        // unmapped and read-only targets
        do_read(8'h58, 0);
        do_write(8'h60, 32'h3, 4'hF, 0, 0, 0);
        do_read(8'h00, 0);
        do_write(8'h04, 32'h1, 4'h1, 1, 0, 0);
        do_write(8'h0C, 32'h1, 4'h1, 0, 2, 1);
        do_write(8'h00, 32'h2, 4'h0, 0, 0, 0);
        do_read(8'h00, 0);

        // randomized traffic
        repeat (160) begin
            int op, k;
            op = $urandom_range(0, 6);
            case (op)
                0, 1: do_write(pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                2, 3: do_read(pick_addr(), $urandom_range(0, 2));
                4: begin
                    cnt_drv[$urandom_range(0, 8)] = {$urandom, $urandom};
                    step();
                end
                5: begin
                    timeout_axil = ~timeout_axil;
                    step();
                end
                default: begin
                    k = $urandom_range(0, 8);
                    do_read(8'(16 + 8 * k), $urandom_range(0, 1));
                    cnt_drv[k] = {$urandom, $urandom};
                    do_read(8'(20 + 8 * k), $urandom_range(0, 1));
                end
            endcase
        end

        // reset while a write response is pending with CTRL=1
        do_write(8'h00, 32'h1, 4'h1, 0, 0, 0);
        bus.awaddr  = 8'h00;
        bus.wdata   = 32'h1;
        bus.wstrb   = 4'h1;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (bus.awready && bus.wready) got = 1'b1;
            end
            if (!got) timeout_fail("rst_test_accept");
            step();
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (bus.bvalid) got = 1'b1;
            end
            if (!got) timeout_fail("rst_test_bvalid");
        end
        check("pre_rst_pause", pause_axil, 1);
        @(posedge clk);
        #3;
        apply_reset();
        #1;
        check("async_rst_bvalid", bus.bvalid, 0);
        check("async_rst_pause", pause_axil, 0);
        check("async_rst_awready", bus.awready, 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        do_read(8'h00, 0);
        do_write(8'h00, 32'h2, 4'h1, 0, 1, 0);
        do_read(8'h00, 0);

        repeat (3) step();
        check("r_queue_drained", exp_r_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/easyobv_axil_regs.md
Name: easyobv_axil_regs

Overview:
AXI4-Lite slave register file in the s_axil_aclk domain, directly downstream of the clock-domain-crossing stage. It exposes the synchronised 64-bit statistics counters and the timeout flag to software as read-only registers, and drives the pause and timeout_clr control levels back into the crossing stage. It has one outstanding transaction per channel, 32-bit data, and a coherent lo/hi read of the 64-bit counters.

Parameters:
ADDR_W, 8, AXI-Lite address width in bits; only bits [7:2] are decoded.
ID_VALUE, 32'h0BB5_0001, constant returned by the ID register.

Ports:
s_axil_aclk  in  1  register-file clock.
rst  in  1  reset, asynchronous, active-high.
s_axil_awaddr  in  ADDR_W  write address.
s_axil_awvalid / s_axil_awready  in / out  1  write-address handshake.
s_axil_wdata  in  32  write data.
s_axil_wstrb  in  4  byte strobes.
s_axil_wvalid / s_axil_wready  in / out  1  write-data handshake.
s_axil_bresp  out  2  write response.
s_axil_bvalid / s_axil_bready  out / in  1  write-response handshake.
s_axil_araddr  in  ADDR_W  read address.
s_axil_arvalid / s_axil_arready  in / out  1  read-address handshake.
s_axil_rdata  out  32  read data.
s_axil_rresp  out  2  read response.
s_axil_rvalid / s_axil_rready  out / in  1  read-data handshake.
pause_axil  out  1  CTRL[0] level.
timeout_clr_axil  out  1  CTRL[1] level.
timeout_axil  in  1  synchronised timeout flag.
mismatch_cnt_axil, tx_pkt_cnt_axil, tx_pkt_time_cnt_axil, tx_pkt_timestamp_sum_axil, tx_transferred_size_axil, rx_pkt_cnt_axil, rx_pkt_time_cnt_axil, rx_pkt_timestamp_sum_axil, rx_transferred_size_axil  in  64 each  synchronised counters.

Behaviour:
- Clocking and reset: single clock s_axil_aclk. rst is asynchronous and active-high.
- Reset values: all ready/valid outputs 0; bresp, rresp, rdata 0; CTRL 0 (so pause_axil and timeout_clr_axil are 0); hi_shadow 0; shadow_idx invalid.
- Address map (byte addresses):
  - 0x00 CTRL: RW; bit0 pause, bit1 timeout_clr, other bits read 0.
  - 0x04 STATUS: RO; bit0 timeout_axil.
  - 0x08 ID: RO; returns ID_VALUE.
  - 0x10+8k LO and 0x14+8k HI, for k=0..8, in this order: mismatch, tx_pkt_cnt, tx_pkt_time_cnt, tx_pkt_timestamp_sum, tx_transferred_size, rx_pkt_cnt, rx_pkt_time_cnt, rx_pkt_timestamp_sum, rx_transferred_size. Last register is at 0x54.
  - Any other address: SLVERR (2'b10); reads return 0.
- Write channel:
  - awready is high while no AW is held and bvalid=0; wready is high while no W is held and bvalid=0.
  - AW and W may arrive in either order or in the same cycle; each is captured independently.
  - The cycle after both are held, the write commits, bvalid=1, and both holds clear.
  - bvalid stays high until bready; awready/wready reassert the cycle after the B handshake.
  - CTRL updates only if wstrb[0]=1; pause_axil/timeout_clr_axil change the cycle the write commits.
  - Writes to RO addresses: ignored, bresp OKAY. Unmapped addresses: SLVERR.
- Read channel:
  - arready = !rvalid.
  - On an AR handshake, rdata/rresp are registered and rvalid=1 the next cycle (1-cycle latency).
  - rdata/rresp are held stable until rready. A new AR is accepted only in the cycle after the R handshake.
- Coherent 64-bit read:
  - Reading LO(k) returns counter[31:0] and, in the same cycle, captures counter[63:32] into hi_shadow and sets shadow_idx=k.
  - Reading HI(k) with shadow_idx==k returns hi_shadow and invalidates shadow_idx.
  - Reading HI(k) otherwise returns the live counter[63:32].
- Simultaneous read and write: the channels are independent and both proceed in the same cycle. A read of CTRL in the commit cycle returns the old value.
- Reset asserted mid-transaction: all in-flight state is dropped immediately; no response is produced for it.

Decomposition:
- Package easyobv_axil_pkg:
  - localparam register offsets (CTRL, STATUS, ID, CNT_BASE, CNT_STRIDE=8, NUM_CNT=9);
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - CTRL bit indices.
- One natural sub-module: easyobv_axil_wr_ctrl, holding the AW/W capture, commit strobe and B handshake. Read path, decode and shadow logic stay in the top.

Test Plan:
- Reset, then AW and W in the same cycle: addr 0x00, data 0x3, strb 0x1 -> bvalid 1 cycle after both held, bresp 0; pause_axil=1, timeout_clr_axil=1; readback of 0x00 = 0x3.
- W presented 3 cycles before AW: addr 0x00, data 0x0 -> no bvalid until AW arrives; bready held low 4 cycles -> bvalid held, awready/wready low throughout.
- Coherent read: tx_pkt_cnt_axil=0x1_FFFF_FFFF. Read 0x18 (=0xFFFFFFFF); counter changes to 0x2_0000_0000; read 0x1C -> 0x00000001. A second read of 0x1C -> 0x00000002.
- Read 0x04 with timeout_axil=1 -> 0x1. Read 0x08 -> 0x0BB50001. rvalid exactly 1 cycle after the AR handshake; with rready low for 2 cycles, rdata stays stable.
- Read 0x58 and write 0x60 -> rresp=2'b10 with rdata=0, bresp=2'b10; CTRL unchanged.
- Assert rst while bvalid=1 and CTRL=0x1 -> bvalid=0 and pause_axil=0 immediately, without waiting for a clock edge.
